// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, 2-entry skid buffer and registered ready.
// Optional stall counter port/logic enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_skid #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  if (WIDTH < 1 || CNT_W < 1) begin : g_bad_param
    $error("pipe_stage_skid: WIDTH and CNT_W must be >= 1");
  end

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;

  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] w_main_nxt;
  logic [WIDTH-1:0] w_skid_nxt;
  logic             w_in_xfer;
  logic             w_out_xfer;

  // Ready and valid are pure decodes of the occupancy register.
  assign in_ready   = (r_state != S_TWO);
  assign out_valid  = (r_state != S_EMPTY);
  assign out_data   = r_main;
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      // Payload registers keep their value so out_data stays at the last main beat.
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_xfer) begin
            w_state_nxt = S_ONE;
            w_main_nxt  = in_data;
          end
        end
        S_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            w_main_nxt = in_data;
          end else if (w_in_xfer) begin
            w_state_nxt = S_TWO;
            w_skid_nxt  = in_data;
          end else if (w_out_xfer) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_out_xfer) begin
            w_state_nxt = S_ONE;
            w_main_nxt  = r_skid;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // Saturating count of cycles a beat waits on downstream; flush does not clear it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (out_valid && !out_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid: directed scenarios plus randomized traffic checked
// every cycle against a queue-based model of the stage.
module tb_pipe_stage_skid;

  localparam int WIDTH = 16;
`ifdef PIPE_STAGE_PERF_EN
  localparam int CW = 3;
`else
  localparam int CW = 16;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [CW-1:0]    stall_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  pipe_stage_skid #(.WIDTH(WIDTH), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Model: the stage is a FIFO of at most two beats; out_data shows the head,
  // or the last head value once the FIFO has drained or been flushed.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_last = '0;
  int               m_stall = 0;
  bit               m_ix, m_ox;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_last  = '0;
      m_stall = 0;
    end else begin
      m_ox = (mq.size() > 0) && out_ready;
      m_ix = in_valid && (mq.size() < 2);
      if ((mq.size() > 0) && !out_ready && (m_stall < (1 << CW) - 1)) m_stall++;
      if (mq.size() > 0) m_last = mq[0];
      if (m_ox) void'(mq.pop_front());
      if (flush) mq.delete();
      else if (m_ix) mq.push_back(in_data);
    end
  end

  logic             p_valid = 1'b0;
  logic             p_ready = 1'b0;
  logic             p_flush = 1'b0;
  logic [WIDTH-1:0] p_data  = '0;

  always @(negedge clk) begin
    chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
    chk("out_data", 64'(out_data), 64'((mq.size() > 0) ? mq[0] : m_last));
`ifdef PIPE_STAGE_PERF_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
    if (rst && p_valid && !p_ready && !p_flush && out_valid)
      chk("stable", 64'(out_data), 64'(p_data));
    p_valid = out_valid & rst;
    p_ready = out_ready;
    p_flush = flush;
    p_data  = out_data;
  end

  task automatic idle_inputs();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic push_stalled(input logic [WIDTH-1:0] d);
    in_valid = 1'b1; in_data = d; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    int pv, pr;
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    step();

    // Reset mid-stream in state TWO.
    push_stalled(16'h1234);
    push_stalled(16'h5678);
    chk("pre_rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_data", 64'(out_data), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // Full-rate stream with one-cycle latency.
    out_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      in_valid = 1'b1; in_data = WIDTH'(k);
      step();
      chk("stream_data", 64'(out_data), 64'(k));
      chk("stream_valid", 64'(out_valid), 64'd1);
      chk("stream_ready", 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drain", 64'(out_valid), 64'd0);

    // Back-pressure into the skid entry.
    push_stalled(16'hAAAA);
    chk("bp_one_data", 64'(out_data), 64'hAAAA);
    chk("bp_one_ready", 64'(in_ready), 64'd1);
    push_stalled(16'hBBBB);
    chk("bp_two_ready", 64'(in_ready), 64'd0);
    chk("bp_two_data", 64'(out_data), 64'hAAAA);
    step();
    chk("bp_hold_data", 64'(out_data), 64'hAAAA);
    out_ready = 1'b1;
    step();
    chk("bp_out2_data", 64'(out_data), 64'hBBBB);
    chk("bp_out2_ready", 64'(in_ready), 64'd1);
    step();
    chk("bp_empty", 64'(out_valid), 64'd0);
    chk("bp_last_data", 64'(out_data), 64'hBBBB);

    // Flush in state TWO with an offered beat.
    push_stalled(16'h1111);
    push_stalled(16'h2222);
    flush = 1'b1; in_valid = 1'b1; in_data = 16'hCCCC;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl2_valid", 64'(out_valid), 64'd0);
    chk("fl2_ready", 64'(in_ready), 64'd1);
    // Flush in state ONE while a beat is actually accepted.
    push_stalled(16'h3333);
    flush = 1'b1; in_valid = 1'b1; in_data = 16'hCCCC;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("fl1_valid", 64'(out_valid), 64'd0);
    chk("fl1_ready", 64'(in_ready), 64'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("fl_no_emit", 64'(out_valid), 64'd0);
    end

`ifdef PIPE_STAGE_PERF_EN
    do_reset();
    chk("perf_rst0", 64'(stall_cnt), 64'd0);
    push_stalled(16'h7777);
    repeat (10) step();
    chk("perf_sat", 64'(stall_cnt), 64'd7);
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    chk("perf_flush", 64'(stall_cnt), 64'd7);
    rst = 1'b0;
    #1;
    chk("perf_rst", 64'(stall_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
`endif

    // Randomized traffic in phases of varying load and back-pressure.
    do_reset();
    pv = 50; pr = 50;
    for (int c = 0; c < 10000; c++) begin
      if (c % 1000 == 0) begin
        pv = $urandom_range(10, 95);
        pr = $urandom_range(10, 95);
      end
      in_valid  = ($urandom_range(0, 99) < pv);
      out_ready = ($urandom_range(0, 99) < pr);
      flush     = ($urandom_range(0, 63) == 0);
      in_data   = WIDTH'($urandom);
      step();
    end
    idle_inputs();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
